// File: rtl/klp_arb_pkg.sv
// Shared arbiter types: FSM state encoding and the 3:1 mux select codes.
package klp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Select encoding of the downstream 3:1 mux; 11 forces a zero output.
  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

endpackage

// File: rtl/arb_pick3.sv
// Combinational 3-way winner picker: searches req_i starting at start_i and
// wrapping, returning a one-hot winner and the matching mux select.
module arb_pick3
  import klp_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] start_i,
  output logic [2:0] winner_o,
  output logic [1:0] sel_o
);

  logic       found;
  logic [1:0] idx;

  // First requester found from the start pointer onward wins.
  always_comb begin
    winner_o = 3'b000;
    sel_o    = SEL_IDLE;
    found    = 1'b0;
    idx      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      idx = 2'((int'(start_i) + i) % 3);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = 3'b001 << idx;
        case (idx)
          2'd0:    sel_o = SEL_REQ0;
          2'd1:    sel_o = SEL_REQ1;
          default: sel_o = SEL_REQ2;
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter3.sv
// Three-requester arbiter/sequencer for the shared KLP32 memory path.
// Holds a grant until mem_ready_i or watchdog abort after TIMEOUT_CYCLES.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed 0 > 1 > 2.
module mem_port_arbiter3
  import klp_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       mem_valid_o,
  input  logic       mem_ready_i,
  output logic [2:0] done_o,
  output logic       timeout_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q;
  logic [2:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             mem_valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       start_ptr;
  logic [2:0]       pick_gnt;
  logic [1:0]       pick_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner_q;

  // Priority begins just after the previous owner, wrapping 2 -> 0.
  always_comb start_ptr = (last_owner_q == 2'd2) ? 2'd0 : last_owner_q + 2'd1;

  // Track the owner on every OWN entry; reset value gives requester 0 first turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 2'd2;
    end else if (state_q == IDLE && |req_i) begin
      last_owner_q <= pick_sel;
    end
  end
`else
  assign start_ptr = 2'd0;
`endif

  arb_pick3 u_pick (
    .req_i    (req_i),
    .start_i  (start_ptr),
    .winner_o (pick_gnt),
    .sel_o    (pick_sel)
  );

  // Saturating watchdog increment.
  always_comb cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // IDLE/OWN sequencer with registered grant, select and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 3'b000;
      sel_q       <= SEL_IDLE;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|req_i) begin
            state_q     <= OWN;
            gnt_q       <= pick_gnt;
            sel_q       <= pick_sel;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        OWN: begin
          // Completion beats the watchdog on the final cycle.
          if (mem_ready_i || cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            gnt_q       <= 3'b000;
            sel_q       <= SEL_IDLE;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            timeout_q   <= ~mem_ready_i;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign mem_valid_o = mem_valid_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;
  assign done_o      = gnt_q & {3{mem_ready_i}};

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Scoreboard bench for mem_port_arbiter3 (TIMEOUT_CYCLES = 4). Follows
// ARB_ROUND_ROBIN_EN to choose expected contention order.
module tb_mem_port_arbiter3;

  logic       clk;
  logic       rst;
  logic [2:0] req_i;
  logic [2:0] gnt_o;
  logic [1:0] sel_o;
  logic       mem_valid_o;
  logic       mem_ready_i;
  logic [2:0] done_o;
  logic       timeout_o;
  logic       busy_o;

  int vectors;
  int errors;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mv;
    logic [2:0] done;
    logic       tmo;
    logic       busy;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic       rdy;
    obs_t       exp;
  } step_t;

  step_t plan_q[$];
  obs_t  exp_q[$];

  mem_port_arbiter3 #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .sel_o       (sel_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t idle_exp(input logic tmo);
    obs_t o;
    o.gnt = 3'b000; o.sel = 2'b11; o.mv = 1'b0;
    o.done = 3'b000; o.tmo = tmo; o.busy = 1'b0;
    return o;
  endfunction

  function automatic obs_t own_exp(input logic [2:0] g, input logic rdy);
    obs_t o;
    o.gnt = g;
    o.sel = (g == 3'b001) ? 2'b00 : (g == 3'b010) ? 2'b01 : 2'b10;
    o.mv = 1'b1;
    o.done = rdy ? g : 3'b000;
    o.tmo = 1'b0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.gnt = gnt_o; o.sel = sel_o; o.mv = mem_valid_o;
    o.done = done_o; o.tmo = timeout_o; o.busy = busy_o;
    return o;
  endfunction

  task automatic add(input logic r, input logic [2:0] rq, input logic rd, input obs_t e);
    step_t s;
    s.rst = r; s.req = rq; s.rdy = rd; s.exp = e;
    plan_q.push_back(s);
  endtask

  // Apply inputs for one cycle, 1 ns after the rising edge.
  task automatic drive(input logic r, input logic [2:0] rq, input logic rd);
    @(posedge clk);
    #1;
    rst = r; req_i = rq; mem_ready_i = rd;
  endtask

  task automatic test_reset();
    step_t s; obs_t e; obs_t got;
    add(1'b1, 3'b111, 1'b0, idle_exp(1'b0));
    add(1'b1, 3'b111, 1'b1, idle_exp(1'b0));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  task automatic test_single();
    step_t s; obs_t e; obs_t got;
    add(1'b0, 3'b010, 1'b0, idle_exp(1'b0));
    add(1'b0, 3'b010, 1'b0, own_exp(3'b010, 1'b0));
    add(1'b0, 3'b010, 1'b1, own_exp(3'b010, 1'b1));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL single c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_own();
    step_t s; obs_t e; obs_t got;
    add(1'b0, 3'b010, 1'b0, idle_exp(1'b0));
    add(1'b1, 3'b010, 1'b0, own_exp(3'b010, 1'b0));
    add(1'b0, 3'b000, 1'b1, idle_exp(1'b0));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_mid c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  task automatic test_contention();
    step_t s; obs_t e; obs_t got;
    logic [2:0] order [4];
`ifdef ARB_ROUND_ROBIN_EN
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    add(1'b1, 3'b000, 1'b0, idle_exp(1'b0));
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 3'b111, 1'b1, idle_exp(1'b0));
      add(1'b0, 3'b111, 1'b1, own_exp(order[k], 1'b1));
    end
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL contention c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s; obs_t e; obs_t got;
    add(1'b0, 3'b100, 1'b0, idle_exp(1'b0));
    for (int k = 0; k < 4; k++) add(1'b0, 3'b100, 1'b0, own_exp(3'b100, 1'b0));
    // Abort pulse; request still high so it is re-arbitrated.
    add(1'b0, 3'b100, 1'b0, idle_exp(1'b1));
    for (int k = 0; k < 3; k++) add(1'b0, 3'b100, 1'b0, own_exp(3'b100, 1'b0));
    // Ready on the final watchdog cycle completes instead of aborting.
    add(1'b0, 3'b100, 1'b1, own_exp(3'b100, 1'b1));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  task automatic test_owner_drop();
    step_t s; obs_t e; obs_t got;
    add(1'b0, 3'b100, 1'b0, idle_exp(1'b0));
    add(1'b0, 3'b000, 1'b0, own_exp(3'b100, 1'b0));
    add(1'b0, 3'b000, 1'b0, own_exp(3'b100, 1'b0));
    add(1'b0, 3'b000, 1'b1, own_exp(3'b100, 1'b1));
    add(1'b0, 3'b000, 1'b0, idle_exp(1'b0));
    for (int c = 0; plan_q.size() > 0; c++) begin
      s = plan_q.pop_front();
      drive(s.rst, s.req, s.rdy);
      exp_q.push_back(s.exp);
      #1;
      e = exp_q.pop_front(); got = sample_dut(); vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL owner_drop c%0d got gnt,sel,mv,done,tmo,busy=%b,%b,%b,%b,%b,%b exp=%b,%b,%b,%b,%b,%b",
                 c, got.gnt, got.sel, got.mv, got.done, got.tmo, got.busy,
                 e.gnt, e.sel, e.mv, e.done, e.tmo, e.busy);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1; req_i = 3'b000; mem_ready_i = 1'b0;
    drive(1'b1, 3'b000, 1'b0);
    test_reset();
    test_single();
    test_reset_mid_own();
    test_contention();
    test_timeout();
    test_owner_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter3.md
# mem_port_arbiter3

Three-requester arbiter and sequencer for a shared single-ported memory/bus path in the KLP32 core. Requesters are instruction fetch, load/store unit and debug/DMA. The block grants one requester at a time and drives the 2-bit select of the downstream 3:1 mux (00→in0, 01→in1, 10→in2, 11→zero output). It holds the grant until the memory completes, and aborts a transaction the memory never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max cycles a grant waits for mem_ready_i before abort; legal range ≥2.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_i  in  3  per-requester request, bit k = requester k; held high until done or timeout
- gnt_o  out  3  one-hot grant, registered
- sel_o  out  2  mux select: 00/01/10 = requester 0/1/2, 11 = idle (mux outputs zero)
- mem_valid_o  out  1  transaction strobe to memory, high for whole ownership
- mem_ready_i  in  1  memory completes the transaction this cycle
- done_o  out  3  one-hot completion, = gnt_o & {3{mem_ready_i}} (combinational)
- timeout_o  out  1  one-cycle pulse, registered, on watchdog abort
- busy_o  out  1  high while in OWN

## Operation
- FSM states: IDLE and OWN.
- IDLE:
  - gnt_o=0, sel_o=11, mem_valid_o=0.
  - If req_i≠0, pick a winner, register gnt_o and sel_o, go to OWN.
  - Counter cleared.
- OWN:
  - mem_valid_o=1.
  - gnt_o and sel_o are frozen.
  - The counter increments each cycle mem_ready_i=0.
  - mem_ready_i=1: done_o pulses for the owner; next state IDLE.
  - Counter reaches TIMEOUT_CYCLES−1 with mem_ready_i=0: abort. timeout_o=1 next cycle, gnt_o cleared, next state IDLE, done_o not asserted.
- mem_ready_i=1 on the final timeout cycle: completion wins, no timeout.
- Owner dropping req_i during OWN is ignored; the grant is held to completion or abort.
- Requester protocol: deassert req_i in the cycle after done_o, unless another transaction follows.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- A requester whose bit is high after abort is re-arbitrated normally.
- Winner selection is described under Configuration.
- Reset (any state, mid-transaction included):
  - State IDLE.
  - gnt_o=0, sel_o=11, mem_valid_o=0, busy_o=0, timeout_o=0.
  - Counter=0, last-owner pointer=2.
  - In-flight transaction is dropped; no done_o.

## Timing
- Arbitration latency: req_i sampled high in IDLE at cycle N → gnt_o, sel_o, mem_valid_o high at N+1.
- Zero-wait memory (ready at N+1): done_o at N+1, IDLE at N+2, next grant earliest N+3.
- Peak throughput: one transaction per 2 cycles. The mandatory idle bubble is intentional.
- Timeout: grant at N+1 with no ready → last OWN cycle is N+TIMEOUT_CYCLES, timeout_o at N+TIMEOUT_CYCLES+1 (state IDLE).
- sel_o changes only on the edge entering/leaving OWN, so mux output is glitch-free with respect to arbitration.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin. Priority starts at (last_owner+1) mod 3 and wraps.
  - last_owner updates on every OWN entry.
  - Reset value 2, so requester 0 has first priority after reset.
- Undefined:
  - Fixed priority 0 > 1 > 2.
  - The last-owner register is not instantiated.

## Structure
- Shared package klp_arb_pkg holds:
  - arb_state_t enum {IDLE, OWN}.
  - Select constants SEL_REQ0=2'b00, SEL_REQ1=2'b01, SEL_REQ2=2'b10, SEL_IDLE=2'b11, matching the 3:1 mux encoding.
- Sub-module arb_pick3, combinational. Inputs: req[2:0], start pointer[1:0]. Outputs: one-hot winner[2:0], sel[1:0].
  - In fixed-priority builds the start pointer is tied to 0.

## Test plan
- Reset mid-OWN, requester 1 granted: assert rst → next cycle gnt_o=000, sel_o=11, mem_valid_o=0, no done_o.
- Single request: req_i=010 at N, mem_ready_i=1 at N+2 → gnt_o=010, sel_o=01 at N+1..N+2; done_o=010 at N+2; sel_o=11 at N+3.
- Contention, fixed priority (macro off): req_i=111 held, ready every OWN cycle → every grant goes to requester 0; sel_o stays 00.
- Contention, round-robin (macro on): req_i=111 held, ready every OWN cycle → grant sequence 0,1,2,0; sel_o 00,01,10,00, with an 11 bubble between each.
- Timeout, TIMEOUT_CYCLES=4: req_i=100, mem_ready_i stuck 0 → OWN for 4 cycles, timeout_o=1 one cycle, gnt_o=000, no done_o. Ready on the 4th OWN cycle instead → done_o=100, timeout_o=0.
- Owner drop: requester 2 granted, req_i→000 mid-OWN → grant held until mem_ready_i; done_o=100 still issued.
